// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU datapath: element width, accumulator
// sizing and the saturating ReLU used at the output of every neuron.
package npu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_N      = 64;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    // Products are 2*DATA_WIDTH wide; summing N of them plus the bias needs
    // $clog2(N+1) growth bits so the accumulator can never wrap.
    function automatic int acc_width(input int n);
        return 2 * DATA_WIDTH + $clog2(n + 1);
    endfunction

    localparam int ACC_MAX_W = acc_width(MAX_N);

    typedef logic signed [ACC_MAX_W-1:0] acc_t;

    localparam data_t DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Negative values (saturated or not) collapse to zero under ReLU, so only
    // the upper clamp is needed explicitly.
    function automatic data_t sat_relu(input acc_t acc);
        if (acc < 0) begin
            return '0;
        end else if (acc > acc_t'(DATA_MAX)) begin
            return DATA_MAX;
        end else begin
            return acc[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Combinational multiply-accumulate: full-precision products of x and w,
// summed together with the sign-extended bias.
module perceptron_mac
    import npu_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = acc_width(N)
) (
    input  data_t                   x [N],
    input  data_t                   w [N],
    input  data_t                   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DATA_WIDTH-1:0] prod [N];

    for (genvar i = 0; i < N; i++) begin : gen_mul
        assign prod[i] = x[i] * w[i];
    end

    always_comb begin
        acc = ACC_W'(b);
        for (int i = 0; i < N; i++) begin
            acc = acc + ACC_W'(prod[i]);
        end
    end

endmodule

// File: rtl/perceptron.sv
// Single neuron: dot product plus bias, saturated to the element width,
// ReLU-activated and registered once per clock.
module perceptron
    import npu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  data_t x [N],
    input  data_t w [N],
    input  data_t b,
    output data_t y
);

    localparam int ACC_W = acc_width(N);

    logic signed [ACC_W-1:0] acc;
    data_t                   y_d;
    data_t                   y_q;

    perceptron_mac #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_mac (
        .x   (x),
        .w   (w),
        .b   (b),
        .acc (acc)
    );

    always_comb begin
        y_d = sat_relu(acc_t'(acc));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_perceptron.sv
// Scoreboard bench for perceptron: directed vectors push hand-computed results
// into a queue, and an independent monitor checks y one edge later.
module tb_perceptron;
    import npu_pkg::*;

    localparam int N = 4;

    logic  clk;
    logic  rst_n;
    data_t x [N];
    data_t w [N];
    data_t b;
    data_t y;

    int    checkCount = 0;
    int    failCount  = 0;

    data_t expQ  [$];
    string nameQ [$];

    perceptron #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .w     (w),
        .b     (b),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input data_t act, input data_t exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: y=%0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive one vector, queue its result, and wait
    // for the next falling edge so the rising edge in between captures it.
    task automatic applyStimulus(input string name,
                                 input int x0, input int x1, input int x2, input int x3,
                                 input int w0, input int w1, input int w2, input int w3,
                                 input int bv, input int expected);
        x[0] = data_t'(x0); x[1] = data_t'(x1); x[2] = data_t'(x2); x[3] = data_t'(x3);
        w[0] = data_t'(w0); w[1] = data_t'(w1); w[2] = data_t'(w2); w[3] = data_t'(w3);
        b    = data_t'(bv);
        expQ.push_back(data_t'(expected));
        nameQ.push_back(name);
        @(negedge clk);
    endtask

    initial begin : monitor
        data_t exp;
        string name;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && expQ.size() > 0) begin
                exp  = expQ.pop_front();
                name = nameQ.pop_front();
                checkOutput(name, y, exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int drain;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            x[i] = data_t'(5);
            w[i] = data_t'(5);
        end
        b = data_t'(3);

        #1;
        checkOutput("reset_initial", y, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", y, '0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("release_dot",   1, 2, 3, 4,   1, 1, 1, 1,   0, 10);
        applyStimulus("bias5",         1, 2, 3, 4,   1, 1, 1, 1,   5, 15);
        applyStimulus("relu_neg",      1, 2, 3, 4,  -1,-1,-1,-1,   0, 0);
        applyStimulus("relu_bias",     0, 0, 0, 0,   0, 0, 0, 0,  -1, 0);
        applyStimulus("sat_300",     100,100, 0, 0,  2, 1, 0, 0,   0, 127);
        applyStimulus("exact_127",   127, 0, 0, 0,   1, 1, 1, 1,   0, 127);
        applyStimulus("exact_127b",  100, 27, 0, 0,  1, 1, 0, 0,   0, 127);
        applyStimulus("plain_126",   100, 26, 0, 0,  1, 1, 0, 0,   0, 126);
        applyStimulus("acc_zero",      1,-1, 0, 0,   1, 1, 0, 0,   0, 0);
        applyStimulus("acc_min",    -128, 0, 0, 0,   1, 1, 1, 1,   0, 0);
        applyStimulus("extreme_pos",-128,-128,-128,-128, -128,-128,-128,-128, -128, 127);
        applyStimulus("extreme_neg",-128,-128,-128,-128,  127, 127, 127, 127, -128, 0);
        applyStimulus("b2b_first",     1, 2, 3, 4,   1, 1, 1, 1,   0, 10);
        applyStimulus("b2b_second",    2, 2, 2, 2,   3, 3, 3, 3,  -4, 20);
        applyStimulus("hold_first",    3, 0, 0, 1,   4, 0, 0, 5,   1, 18);
        applyStimulus("hold_second",   3, 0, 0, 1,   4, 0, 0, 5,   1, 18);
        applyStimulus("pre_async",     5, 5, 5, 5,   5, 5, 5, 5,   0, 100);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", y, '0);
        @(posedge clk);
        #1;
        checkOutput("async_hold", y, '0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rerelease",     2, 3, 0, 0,   4, 5, 0, 0,  -3, 20);

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (expQ.size() > 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule
